// File: rtl/turfio_din_if.sv
// AXI4-Stream byte channel from the TURFIO receive aligner toward the COBS decoder.
interface turfio_din_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/turfio_din.sv
// Receive-side byte aligner for the SURF->TURFIO link: hunts the training byte in the
// nybble stream, locks one of 8 bit alignments and emits framed bytes on AXI4-Stream.
module turfio_din #(
    parameter logic [7:0]  TRAIN_VALUE = 8'h6A,
    parameter int unsigned LOCK_COUNT  = 8,
    parameter logic        INV_DIN     = 1'b0
) (
    input  logic         ifclk_i,
    input  logic         rst_i,
    input  logic [3:0]   din_i,
    input  logic         train_i,
    turfio_din_if.master m_axis,
    output logic         locked_o,
    output logic [1:0]   offset_o,
    output logic [15:0]  err_count_o,
    output logic         overflow_o
);
    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t          state, state_next;
    logic [3:0]      din_x, d1, d2;
    logic [11:0]     hist;
    logic [3:0][7:0] win;
    logic            bp;
    logic [7:0]      match_cnt;
    logic            hunt_hit;
    logic [1:0]      hunt_off;
    logic [7:0]      cur_byte;
    logic            byte_ok;
    logic            emit;
    logic            err_hit;

    // Oldest nybble sits in the low bits, so window b starts b bits into the history.
    assign din_x    = din_i ^ {4{INV_DIN}};
    assign hist     = {din_x, d1, d2};
    assign cur_byte = win[offset_o];
    assign byte_ok  = (cur_byte == TRAIN_VALUE);

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        win      = '0;
        hunt_hit = 1'b0;
        hunt_off = 2'd0;
        for (int b = 3; b >= 0; b--) begin
            win[b] = hist[b +: 8];
            if (hist[b +: 8] == TRAIN_VALUE) begin
                hunt_hit = 1'b1;
                hunt_off = 2'(b);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ifclk_i) begin
        if (rst_i) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            HUNT: begin
                if (hunt_hit) state_next = VERIFY;
            end
            VERIFY: begin
                if (bp) begin
                    if (!byte_ok)                                state_next = HUNT;
                    else if (match_cnt == 8'(LOCK_COUNT - 1))    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (bp && train_i && !byte_ok) state_next = HUNT;
            end
            default: state_next = HUNT;
        endcase
    end

    always_comb begin
        locked_o = (state == LOCKED);
        emit     = (state == LOCKED) && bp && !train_i;
        err_hit  = (state == LOCKED) && bp && train_i && !byte_ok;
    end

    always_ff @(posedge ifclk_i) begin
        if (rst_i) begin
            d1            <= '0;
            d2            <= '0;
            bp            <= 1'b0;
            offset_o      <= 2'd0;
            match_cnt     <= '0;
            err_count_o   <= '0;
            overflow_o    <= 1'b0;
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
        end else begin
            d1 <= din_x;
            d2 <= d1;
            bp <= ~bp;

            // A hunt hit re-phases bp so the next byte window lands two cycles later.
            if (state == HUNT && hunt_hit) begin
                offset_o  <= hunt_off;
                bp        <= 1'b0;
                match_cnt <= 8'd1;
            end else if (state == VERIFY && bp && byte_ok) begin
                match_cnt <= match_cnt + 8'd1;
            end

            if (err_hit && err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;

            m_axis.tvalid <= emit;
            if (emit) m_axis.tdata <= cur_byte;

            // The stream never stalls; a byte offered without tready is dropped and flagged.
            if (m_axis.tvalid && !m_axis.tready) overflow_o <= 1'b1;
        end
    end
endmodule
